// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and load clamp helper for updown_counter_param
package counter_pkg;

    // Boundary behaviour selector for the SATURATE parameter
    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Direction encoding of the up input
    localparam logic CNT_DIR_UP   = 1'b1;
    localparam logic CNT_DIR_DOWN = 1'b0;

    // Limit a load value to the highest legal count; operands are zero-extended by the caller
    function automatic logic [31:0] clamp_to_max(input logic [31:0] val, input logic [31:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// rtl/counter_next_calc.sv - combinational next-count, boundary and terminal-count logic
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] MAX_Q    = '1,
    parameter int               SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    output logic [WIDTH-1:0] next_q,
    output logic             boundary_hit,
    output logic             tc
);

    // Step one count in the selected direction; the boundary compare happens before
    // any arithmetic so no intermediate value ever exceeds MAX_Q
    always_comb begin
        next_q       = q;
        boundary_hit = 1'b0;
        if (en) begin
            if (up == CNT_DIR_UP) begin
                if (q == MAX_Q) begin
                    boundary_hit = 1'b1;
                    if (SATURATE == CNT_MODE_WRAP) begin
                        next_q = '0;
                    end
                end else begin
                    next_q = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    boundary_hit = 1'b1;
                    if (SATURATE == CNT_MODE_WRAP) begin
                        next_q = MAX_Q;
                    end
                end else begin
                    next_q = q - WIDTH'(1);
                end
            end
        end
    end

    // Terminal count is exactly the condition that produces a boundary event on the next edge
    assign tc = boundary_hit;

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter; UPDOWN_COUNTER_OVF_STICKY_EN adds ovf_sticky
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 3,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    ,
    output logic             ovf_sticky
`endif
);

    // Reject illegal configurations at elaboration rather than building a silently wrong counter
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("updown_counter_param: WIDTH must be in 1..32");
        end
        if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("updown_counter_param: MAX_VAL must be in 1..2**WIDTH-1");
        end
        if (SATURATE != CNT_MODE_WRAP && SATURATE != CNT_MODE_SAT) begin : g_bad_mode
            $error("updown_counter_param: SATURATE must be 0 or 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] load_q;
    logic             boundary_hit;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MAX_Q    (MAX_Q),
        .SATURATE (SATURATE)
    ) u_next_calc (
        .q            (q),
        .up           (up),
        .en           (en),
        .next_q       (next_q),
        .boundary_hit (boundary_hit),
        .tc           (tc)
    );

    assign load_q = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX_Q)));

    // Count register and wrap pulse with clr > load > en > hold priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_q;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= next_q;
            wrap <= boundary_hit;
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    // Sticky overflow: set alongside every wrap pulse, survives load, cleared only by clr or reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            ovf_sticky <= 1'b0;
        end else if (!load && boundary_hit) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the team's fixed 3-bit up counter.
- Generalised in width and modulus; adds direction control, count enable, synchronous load and clear, wrap/saturate mode, and terminal-count/wrap indication.
- Used as the general-purpose event/cycle counter across the design: divider chains, timeouts and index generation.

Parameters:
- WIDTH, 3: counter width in bits; legal range 1..32.
- MAX_VAL, 2**WIDTH-1: highest count value; count range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronous to clk by the upstream reset synchroniser.
- en  input  1  count enable; count steps by one per clk when high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load; clamped to MAX_VAL.
- q  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count: en & ((up & q==MAX_VAL) | (~up & q==0)).
- wrap  output  1  registered one-cycle pulse, asserted in the cycle after a wrap or saturate event.

Behaviour:
- Reset (rst=0, asynchronous): q=0, wrap=0, and ovf_sticky=0 when present. Reset mid-count discards state immediately; counting resumes from 0 on the first enabled edge after release.
- Priority per rising edge: clr > load > en > hold.
- clr=1: q<=0; wrap<=0. Overrides load and en in the same cycle.
- load=1 (clr=0): q<=min(load_val, MAX_VAL); wrap<=0; no count step that cycle, regardless of en.
- en=1 & up=1:
  - q<MAX_VAL: q<=q+1.
  - q==MAX_VAL, SATURATE=0: q<=0, wrap<=1.
  - q==MAX_VAL, SATURATE=1: q holds, wrap<=1.
- en=1 & up=0:
  - q>0: q<=q-1.
  - q==0, SATURATE=0: q<=MAX_VAL, wrap<=1.
  - q==0, SATURATE=1: q holds, wrap<=1.
- en=0: q holds; wrap<=0.
- wrap is high for exactly one cycle per boundary event. A continuous saturated count at the boundary re-asserts wrap every enabled cycle.
- Latency: q reflects an input change one clk after sampling. tc is same-cycle combinational, so tc=1 in exactly the cycle whose edge produces the wrap.
- Arithmetic is WIDTH bits wide. No intermediate value exceeds MAX_VAL, so there is no implicit modular overflow when MAX_VAL < 2**WIDTH-1.
- Direction change mid-count takes effect on the next enabled edge; no dead cycle.
- Out-of-range parameters: an elaboration-time check stops compilation with an error.
- All sequential logic uses non-blocking assignment.

Optional Feature:
- Macro: UPDOWN_COUNTER_OVF_STICKY_EN.
- Defined: adds output port ovf_sticky (1 bit, registered).
  - Set on any cycle where wrap is set; stays set.
  - Cleared only by clr=1 or reset.
  - load does not clear it.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1, used for SATURATE;
  - direction constants CNT_DIR_UP=1 and CNT_DIR_DOWN=0;
  - a clamp function for load_val against MAX_VAL.
- One sub-module is natural: counter_next_calc. It is combinational and takes q, up, en, MAX_VAL and SATURATE, and produces next_q, boundary_hit and tc. The top level holds the registers, priority logic and the optional sticky flag.

Test Plan:
- WIDTH=3, defaults: release reset, en=1, up=1 for 9 cycles -> q=1,2,...,7,0,1; tc=1 while q=7; wrap pulses one cycle after q 7->0.
- WIDTH=3, MAX_VAL=5, up=0 from q=0 -> q=5,4,3; wrap pulse after 0->5; tc=1 in the q=0 cycle.
- SATURATE=1, up=1 for 10 cycles -> q sticks at 7; wrap re-asserts each cycle at the boundary; with the macro defined, ovf_sticky=1 and remains 1 after en=0.
- clr=1, load=1, load_val=4, en=1 in the same cycle -> q=0. Next cycle load=1 only, load_val=6, MAX_VAL=5 -> q=5 with no count step.
- Assert rst=0 asynchronously mid-cycle at q=3 -> q=0 and wrap=0 before the next clk edge; after release, en=1 gives q=1.
- Toggle up every cycle with en=1 starting at q=2 -> q=3,2,3,2; no wrap.
